// File: rtl/ahb_master_arbiter_if.sv
// One AHB-Lite link: a master-to-slave address/control/write-data path and its
// return path. Used for each master port and for the shared S0 port.
interface ahb_master_arbiter_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HMASTLOCK;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  // Handshake: an address phase is accepted on a rising edge where HREADY=1
  // and HTRANS[1]=1; the data phase completes on the next edge with HREADY=1.
  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter onto the S0 slave port. Hold-until-idle grant
// that respects HMASTLOCK; only the non-granted master is stalled.
module ahb_master_arbiter #(
  parameter bit DEFAULT_GRANT = 1'b0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_master_arbiter_if.slave   m0,
  ahb_master_arbiter_if.slave   m1,
  ahb_master_arbiter_if.master  s0,
  output logic                  HMASTER,
  output logic                  dbg_dphase_valid_o,
  output logic                  dbg_dphase_master_o
);

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} grant_e;

  grant_e grant_q, grant_d;
  logic   dphase_valid_q, dphase_valid_d;
  logic   dphase_master_q, dphase_master_d;

  logic [1:0] owner_trans;
  logic       owner_lock;
  logic       other_req;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q         <= grant_e'(DEFAULT_GRANT);
      dphase_valid_q  <= 1'b0;
      dphase_master_q <= DEFAULT_GRANT;
    end else begin
      grant_q         <= grant_d;
      dphase_valid_q  <= dphase_valid_d;
      dphase_master_q <= dphase_master_d;
    end
  end

  always_comb begin
    grant_d         = grant_q;
    dphase_valid_d  = dphase_valid_q;
    dphase_master_d = dphase_master_q;

    owner_trans = (grant_q == OWN1) ? m1.HTRANS    : m0.HTRANS;
    owner_lock  = (grant_q == OWN1) ? m1.HMASTLOCK : m0.HMASTLOCK;
    other_req   = (grant_q == OWN1) ? m0.HTRANS[1] : m1.HTRANS[1];

    // The owner only lets go once its IDLE address phase is accepted, so it
    // never has a real data phase outstanding when the grant moves.
    if (s0.HREADY) begin
      dphase_valid_d  = s0.HTRANS[1];
      dphase_master_d = grant_q;
      if (!owner_trans[1] && !owner_lock && other_req) begin
        grant_d = (grant_q == OWN1) ? OWN0 : OWN1;
      end
    end
  end

  // Address-phase mux follows the current grant with no added latency.
  always_comb begin
    s0.HADDR     = m0.HADDR;
    s0.HTRANS    = m0.HTRANS;
    s0.HWRITE    = m0.HWRITE;
    s0.HSIZE     = m0.HSIZE;
    s0.HBURST    = m0.HBURST;
    s0.HPROT     = m0.HPROT;
    s0.HMASTLOCK = m0.HMASTLOCK;
    if (grant_q == OWN1) begin
      s0.HADDR     = m1.HADDR;
      s0.HTRANS    = m1.HTRANS;
      s0.HWRITE    = m1.HWRITE;
      s0.HSIZE     = m1.HSIZE;
      s0.HBURST    = m1.HBURST;
      s0.HPROT     = m1.HPROT;
      s0.HMASTLOCK = m1.HMASTLOCK;
    end
  end

  // Write data belongs to whoever owned the previous accepted address phase.
  always_comb begin
    s0.HWDATA = dphase_master_q ? m1.HWDATA : m0.HWDATA;
  end

  // Non-granted master sees a stall only while it is requesting.
  always_comb begin
    m0.HRDATA = s0.HRDATA;
    m1.HRDATA = s0.HRDATA;
    if (grant_q == OWN1) begin
      m1.HREADY = s0.HREADY;
      m1.HRESP  = s0.HRESP;
      m0.HREADY = ~m0.HTRANS[1];
      m0.HRESP  = 1'b0;
    end else begin
      m0.HREADY = s0.HREADY;
      m0.HRESP  = s0.HRESP;
      m1.HREADY = ~m1.HTRANS[1];
      m1.HRESP  = 1'b0;
    end
  end

  assign HMASTER             = grant_q;
  assign dbg_dphase_valid_o  = dphase_valid_q;
  assign dbg_dphase_master_o = dphase_master_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: reset, single write, burst handover,
// locked hold, slave wait states, ERROR response and mid-transfer reset.
module tb_ahb_master_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic HCLK;
  logic HRESETn;
  logic HMASTER;
  logic dbg_dphase_valid;
  logic dbg_dphase_master;

  ahb_master_arbiter_if m0_if ();
  ahb_master_arbiter_if m1_if ();
  ahb_master_arbiter_if s0_if ();

  ahb_master_arbiter #(.DEFAULT_GRANT(1'b0)) dut (
    .HCLK                (HCLK),
    .HRESETn             (HRESETn),
    .m0                  (m0_if),
    .m1                  (m1_if),
    .s0                  (s0_if),
    .HMASTER             (HMASTER),
    .dbg_dphase_valid_o  (dbg_dphase_valid),
    .dbg_dphase_master_o (dbg_dphase_master)
  );

  // clock / reset
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // drivers
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic m0_drive(input logic [1:0] trans, input logic [31:0] addr, input logic lock);
    m0_if.HTRANS    = trans;
    m0_if.HADDR     = addr;
    m0_if.HMASTLOCK = lock;
  endtask

  task automatic m1_drive(input logic [1:0] trans, input logic [31:0] addr, input logic lock);
    m1_if.HTRANS    = trans;
    m1_if.HADDR     = addr;
    m1_if.HMASTLOCK = lock;
  endtask

  task automatic s0_drive(input logic ready, input logic resp, input logic [31:0] rdata);
    s0_if.HREADY = ready;
    s0_if.HRESP  = resp;
    s0_if.HRDATA = rdata;
  endtask

  initial begin
    HRESETn = 1'b0;
    m0_drive(IDLE, 32'h0, 1'b0);
    m1_drive(IDLE, 32'h0, 1'b0);
    m0_if.HWRITE = 1'b0; m0_if.HSIZE = 3'b010; m0_if.HBURST = 3'b000; m0_if.HPROT = 4'h3;
    m1_if.HWRITE = 1'b0; m1_if.HSIZE = 3'b010; m1_if.HBURST = 3'b000; m1_if.HPROT = 4'h1;
    m0_if.HWDATA = 32'h0;
    m1_if.HWDATA = 32'hDEAD_BEEF;
    s0_drive(1'b1, 1'b0, 32'h0);

    // reset state
    #2;
    check("rst_hmaster", {31'd0, HMASTER}, 32'd0);
    check("rst_hready0", {31'd0, m0_if.HREADY}, 32'd1);
    check("rst_hready1", {31'd0, m1_if.HREADY}, 32'd1);
    check("rst_hresp0", {31'd0, m0_if.HRESP}, 32'd0);
    check("rst_hresp1", {31'd0, m1_if.HRESP}, 32'd0);
    check("rst_htrans", {30'd0, s0_if.HTRANS}, 32'd0);
    check("rst_dvalid", {31'd0, dbg_dphase_valid}, 32'd0);
    #10 HRESETn = 1'b1;

    // M0 single write
    step();
    m0_drive(NONSEQ, 32'h2000_0000, 1'b0);
    m0_if.HWRITE = 1'b1;
    exp_q.push_back(32'hA5A5_5A5A);
    #1;
    check("wr_haddr", s0_if.HADDR, 32'h2000_0000);
    check("wr_htrans", {30'd0, s0_if.HTRANS}, {30'd0, NONSEQ});
    check("wr_hwrite", {31'd0, s0_if.HWRITE}, 32'd1);
    check("wr_hprot", {28'd0, s0_if.HPROT}, 32'h3);
    step();
    m0_drive(IDLE, 32'h0, 1'b0);
    m0_if.HWRITE = 1'b0;
    m0_if.HWDATA = 32'hA5A5_5A5A;
    #1;
    check("wr_hwdata", s0_if.HWDATA, exp_q.pop_front());
    check("wr_hready0", {31'd0, m0_if.HREADY}, 32'd1);
    check("wr_dvalid", {31'd0, dbg_dphase_valid}, 32'd1);

    // M0 INCR4 read; M1 NONSEQ arrives in beat 2
    step();
    m0_if.HBURST = 3'b011;
    m0_drive(NONSEQ, 32'h0000_1000, 1'b0);
    #1;
    check("b_a_hready1", {31'd0, m1_if.HREADY}, 32'd1);
    step();
    m0_drive(SEQ, 32'h0000_1004, 1'b0);
    m1_drive(NONSEQ, 32'h4000_0000, 1'b0);
    #1;
    check("b_b_hready1", {31'd0, m1_if.HREADY}, 32'd0);
    check("b_b_haddr", s0_if.HADDR, 32'h0000_1004);
    check("b_b_hmaster", {31'd0, HMASTER}, 32'd0);
    check("b_b_hburst", {29'd0, s0_if.HBURST}, 32'd3);
    step();
    m0_drive(SEQ, 32'h0000_1008, 1'b0);
    #1;
    check("b_c_hready1", {31'd0, m1_if.HREADY}, 32'd0);
    step();
    m0_drive(SEQ, 32'h0000_100C, 1'b0);
    #1;
    check("b_d_hready1", {31'd0, m1_if.HREADY}, 32'd0);
    check("b_d_hmaster", {31'd0, HMASTER}, 32'd0);
    step();
    m0_drive(IDLE, 32'h0, 1'b0);
    #1;
    check("b_e_hready1", {31'd0, m1_if.HREADY}, 32'd0);
    check("b_e_hmaster", {31'd0, HMASTER}, 32'd0);
    step();
    s0_if.HRDATA = 32'h0000_1234;
    #1;
    check("b_f_hmaster", {31'd0, HMASTER}, 32'd1);
    check("b_f_haddr", s0_if.HADDR, 32'h4000_0000);
    check("b_f_hready1", {31'd0, m1_if.HREADY}, 32'd1);
    check("b_f_hready0", {31'd0, m0_if.HREADY}, 32'd1);
    check("b_f_hrdata0", m0_if.HRDATA, 32'h0000_1234);
    check("b_f_hburst", {29'd0, s0_if.HBURST}, 32'd0);

    // M1 locked across IDLE while M0 requests
    step();
    m1_drive(IDLE, 32'h0, 1'b1);
    m0_drive(NONSEQ, 32'h2000_0100, 1'b0);
    #1;
    check("lk_g_hmaster", {31'd0, HMASTER}, 32'd1);
    check("lk_g_hready0", {31'd0, m0_if.HREADY}, 32'd0);
    check("lk_g_hmastlock", {31'd0, s0_if.HMASTLOCK}, 32'd1);
    step();
    #1;
    check("lk_h_hmaster", {31'd0, HMASTER}, 32'd1);
    check("lk_h_hready0", {31'd0, m0_if.HREADY}, 32'd0);
    step();
    m1_drive(IDLE, 32'h0, 1'b0);
    #1;
    check("lk_i_hmaster", {31'd0, HMASTER}, 32'd1);
    check("lk_i_hready0", {31'd0, m0_if.HREADY}, 32'd0);
    step();
    #1;
    check("lk_j_hmaster", {31'd0, HMASTER}, 32'd0);
    check("lk_j_haddr", s0_if.HADDR, 32'h2000_0100);
    check("lk_j_hready0", {31'd0, m0_if.HREADY}, 32'd1);

    // S0 wait states on an M1 read
    step();
    m0_drive(IDLE, 32'h0, 1'b0);
    m1_drive(NONSEQ, 32'h4000_0010, 1'b0);
    #1;
    check("ws_k_hready1", {31'd0, m1_if.HREADY}, 32'd0);
    step();
    #1;
    check("ws_l_hmaster", {31'd0, HMASTER}, 32'd1);
    check("ws_l_hready1", {31'd0, m1_if.HREADY}, 32'd1);
    step();
    m1_drive(IDLE, 32'h0, 1'b0);
    m0_drive(NONSEQ, 32'h2000_0200, 1'b0);
    s0_drive(1'b0, 1'b0, 32'h0);
    for (int w = 0; w < 3; w++) begin
      #1;
      check($sformatf("ws%0d_hready1", w), {31'd0, m1_if.HREADY}, 32'd0);
      check($sformatf("ws%0d_hready0", w), {31'd0, m0_if.HREADY}, 32'd0);
      check($sformatf("ws%0d_hmaster", w), {31'd0, HMASTER}, 32'd1);
      check($sformatf("ws%0d_dmaster", w), {31'd0, dbg_dphase_master}, 32'd1);
      step();
    end
    s0_drive(1'b1, 1'b0, 32'hCAFE_F00D);
    #1;
    check("ws_end_hready1", {31'd0, m1_if.HREADY}, 32'd1);
    check("ws_end_hrdata1", m1_if.HRDATA, 32'hCAFE_F00D);
    check("ws_end_hmaster", {31'd0, HMASTER}, 32'd1);
    check("ws_end_hready0", {31'd0, m0_if.HREADY}, 32'd0);
    step();
    #1;
    check("ws_sw_hmaster", {31'd0, HMASTER}, 32'd0);
    check("ws_sw_hready0", {31'd0, m0_if.HREADY}, 32'd1);
    check("ws_sw_haddr", s0_if.HADDR, 32'h2000_0200);

    // ERROR response to M0, then reset mid-burst
    step();
    m0_if.HBURST = 3'b001;
    m0_drive(SEQ, 32'h2000_0204, 1'b0);
    m1_drive(NONSEQ, 32'h4000_0020, 1'b0);
    s0_drive(1'b0, 1'b1, 32'h0);
    #1;
    check("er1_hresp0", {31'd0, m0_if.HRESP}, 32'd1);
    check("er1_hready0", {31'd0, m0_if.HREADY}, 32'd0);
    check("er1_hresp1", {31'd0, m1_if.HRESP}, 32'd0);
    check("er1_hready1", {31'd0, m1_if.HREADY}, 32'd0);
    step();
    m0_drive(IDLE, 32'h0, 1'b0);
    s0_drive(1'b1, 1'b1, 32'h0);
    #1;
    check("er2_hresp0", {31'd0, m0_if.HRESP}, 32'd1);
    check("er2_hready0", {31'd0, m0_if.HREADY}, 32'd1);
    check("er2_hmaster", {31'd0, HMASTER}, 32'd0);
    step();
    s0_drive(1'b1, 1'b0, 32'h0);
    #1;
    check("er3_hmaster", {31'd0, HMASTER}, 32'd1);
    check("er3_haddr", s0_if.HADDR, 32'h4000_0020);
    check("er3_hready1", {31'd0, m1_if.HREADY}, 32'd1);
    step();
    m1_drive(SEQ, 32'h4000_0024, 1'b0);
    #1;
    check("er4_dvalid", {31'd0, dbg_dphase_valid}, 32'd1);
    check("er4_dmaster", {31'd0, dbg_dphase_master}, 32'd1);
    #1 HRESETn = 1'b0;
    #1;
    check("ar_hmaster", {31'd0, HMASTER}, 32'd0);
    check("ar_dvalid", {31'd0, dbg_dphase_valid}, 32'd0);
    check("ar_dmaster", {31'd0, dbg_dphase_master}, 32'd0);
    check("ar_hready1", {31'd0, m1_if.HREADY}, 32'd0);
    check("ar_htrans", {30'd0, s0_if.HTRANS}, 32'd0);
    #1 HRESETn = 1'b1;
    m1_drive(IDLE, 32'h0, 1'b0);
    step();
    #1;
    check("park_hmaster", {31'd0, HMASTER}, 32'd0);
    check("park_hready1", {31'd0, m1_if.HREADY}, 32'd1);

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Two-master AHB-Lite arbiter that shares the bus-matrix S0 slave interface between the Cortex-M0 (master 0) and a second bus master such as a DMA engine (master 1). Master 1 is the DMA engine, for example. The block sits between both masters and the S0 port. Arbitration uses a hold-until-idle scheme that honours HMASTLOCK. Wait states are inserted only on the master that is not granted.

## Interface
- DEFAULT_GRANT, 0: master granted (and parked) out of reset.
- HCLK  in  1  system clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR0 / HADDR1  in  32  master address.
- HTRANS0 / HTRANS1  in  2  master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HWRITE0 / HWRITE1, HSIZE0 / HSIZE1 [2:0], HBURST0 / HBURST1 [2:0], HPROT0 / HPROT1 [3:0]  in  master control.
- HWDATA0 / HWDATA1  in  32  master write data.
- HMASTLOCK0 / HMASTLOCK1  in  1  locked sequence.
- HRDATA0 / HRDATA1  out  32  read data (both driven from HRDATA).
- HREADY0 / HREADY1  out  1  per-master ready.
- HRESP0 / HRESP1  out  1  per-master response.
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK  out  32/2/1/3/3/4/1  muxed address phase to S0.
- HWDATA  out  32  write data muxed by the data-phase owner.
- HMASTER  out  1  current grant.
- HRDATA  in  32, HREADY  in  1, HRESP  in  1  S0 return path.

## Operation
- Per-master state: grant (1 bit, two states OWN0 and OWN1) and dphase_valid/dphase_master registers. All are updated only on edges where HREADY=1.
- Request: master m requests when HTRANSm[1]=1.
- Grant update at an edge with HREADY=1, where owner = grant and other = !grant:
  - The grant is kept if owner HTRANS[1]=1 or owner HMASTLOCK=1.
  - Otherwise, if the other master requests, grant ← other.
  - Otherwise the grant stays parked on the owner.
- A switch therefore occurs only after the owner's IDLE address phase has been accepted. The old owner never has an outstanding real data phase after a switch.
- Address mux: HADDR, HTRANS and the other address-phase controls, plus HMASTLOCK, come from the granted master combinationally.
- Data phase registers: dphase_valid ← HTRANS[1] (output) and dphase_master ← grant. HWDATA = HWDATA[dphase_master].
- Granted master: HREADYm = HREADY, HRESPm = HRESP.
- Non-granted master: HRESPm = 0, and HREADYm = !HTRANSm[1]. The denied NONSEQ is stalled, and the master holds its address per AHB rules.
- Error: the two-cycle ERROR response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1) passes unmodified to the owner.
  - If the owner drops to IDLE in the second error cycle, the grant may switch at that edge.
- Starvation: an owner issuing continuous non-IDLE transfers keeps the grant; there is no preemption. Masters must issue IDLE between bursts.
- Reset mid-transfer: all state returns to reset values asynchronously. Any in-flight data phase is abandoned.

## Timing
- Reset values:
  - grant = DEFAULT_GRANT, dphase_valid = 0, dphase_master = DEFAULT_GRANT.
  - Outputs follow: HMASTER = DEFAULT_GRANT, HTRANS = HTRANS[DEFAULT_GRANT], HREADY of the non-default master = !HTRANS[1].
- The arbiter adds zero latency for the owner; the address and data paths are combinational.
- Switch latency: the owner's IDLE is accepted at edge N, and grant flips at N. The waiting master's NONSEQ appears on HTRANS in cycle N+1 and is accepted at N+1 when HREADY=1. That master therefore sees exactly one HREADY=0 cycle if it requested in cycle N.
- The grant never changes while HREADY=0.
- Both masters idle: no switch (parked), HMASTER stable.
- Simultaneous NONSEQ from both masters with the owner idle the previous cycle: the owner keeps the grant, and the other is stalled.

## Test plan
- Reset with DEFAULT_GRANT=0, both masters IDLE:
  - HMASTER=0, HREADY0=HREADY1=1, HRESP0=HRESP1=0, HTRANS=00.
- M0 single write to 0x2000_0000 with data 0xA5A5_5A5A and S0 zero-wait:
  - HADDR=0x2000_0000 in the address cycle.
  - HWDATA=0xA5A5_5A5A the next cycle, then HREADY0=1.
- M0 INCR4 read while M1 issues NONSEQ to 0x4000_0000 in beat 2:
  - HREADY1=0 until M0 presents IDLE.
  - HMASTER becomes 1 one cycle later, and HADDR=0x4000_0000 is accepted with one extra wait cycle for M1.
- M1 owner with HMASTLOCK1=1 across IDLE cycles while M0 requests:
  - Grant stays 1 until HMASTLOCK1=0 and HTRANS1=IDLE, then it switches to 0.
- S0 inserts 3 wait states on an M1 read:
  - HREADY1 mirrors HREADY, the grant is frozen, and M0's NONSEQ is stalled for all 3 cycles.
- ERROR response to M0 plus HRESETn pulsed low mid-burst:
  - HRESP0=1 for 2 cycles with HREADY0=0 then 1.
  - The async reset immediately forces HMASTER=DEFAULT_GRANT, dphase_valid=0.
